// File: rtl/memif_dma_pkg.sv
// Shared definitions for the memif copy DMA.
//   - FSM state encoding (plain 3-bit constants, legacy-compatible)
//   - byte strobe used for full-word accesses
//   - per-word address increment
package memif_dma_pkg;

   typedef logic [2:0] dma_state_t;

   localparam dma_state_t ST_IDLE   = 3'd0;
   localparam dma_state_t ST_RD_REQ = 3'd1;
   localparam dma_state_t ST_RD_RSP = 3'd2;
   localparam dma_state_t ST_WR_REQ = 3'd3;
   localparam dma_state_t ST_WR_RSP = 3'd4;

   localparam logic [3:0]  MEMIF_STRB_WORD = 4'hF;
   localparam logic [31:0] WORD_INC        = 32'd4;

endpackage

// File: rtl/memif_copy_dma.sv
// memif_copy_dma: word-copy DMA acting as a REQ-side initiator on the CCX
// memory interface. Reads one word from src, writes it to dst, repeats for
// cfg_len words. Stops on the first error response.
//
// Ports:
//   g_clk, g_resetn        clock, synchronous active-low reset
//   g_clk_req              clock request (busy, start pending or FSM active)
//   cfg_start/src/dst/len  transfer setup; start ignored while busy
//   busy, done, err        status; done/err sticky until next accepted start
//   err_addr, words_left   faulting address, remaining word count
//   memif_*                req/gnt initiator port, responses per RSP_DELAY
//
// state     | meaning
// ----------+-----------------------------------------------------
// IDLE      | waiting for cfg_start
// RD_REQ    | read request to src_ptr held until gnt
// RD_RSP    | read response cycle (RSP_DELAY=1 only), req low
// WR_REQ    | write of buffer to dst_ptr held until gnt
// WR_RSP    | write response cycle (RSP_DELAY=1 only), req low
module memif_copy_dma
   import memif_dma_pkg::*;
#(
   parameter int LEN_W     = 16,
   parameter int RSP_DELAY = 0
) (
   input  logic             g_clk,
   input  logic             g_resetn,
   output logic             g_clk_req,
   input  logic             cfg_start,
   input  logic [31:0]      cfg_src,
   input  logic [31:0]      cfg_dst,
   input  logic [LEN_W-1:0] cfg_len,
   output logic             busy,
   output logic             done,
   output logic             err,
   output logic [31:0]      err_addr,
   output logic [LEN_W-1:0] words_left,
   output logic             memif_req,
   input  logic             memif_gnt,
   output logic             memif_wen,
   output logic [3:0]       memif_strb,
   output logic [31:0]      memif_addr,
   output logic [31:0]      memif_wdata,
   input  logic [31:0]      memif_rdata,
   input  logic             memif_error
);

   localparam logic DLY = (RSP_DELAY != 0);

   dma_state_t  state;
   logic [31:0] src_ptr;
   logic [31:0] dst_ptr;
   logic [31:0] buffer;
   logic [31:0] addr_sel;
   logic        in_req;
   logic        rsp_wr;
   logic        rsp_valid;

   // rsp_valid marks the cycle in which rdata/error belong to our access:
   // the gnt cycle itself, or the dedicated response state one cycle later.
   always_comb begin
      in_req   = (state == ST_RD_REQ) || (state == ST_WR_REQ);
      rsp_wr   = (state == ST_WR_REQ) || (state == ST_WR_RSP);
      if (DLY) begin
         rsp_valid = (state == ST_RD_RSP) || (state == ST_WR_RSP);
      end else begin
         rsp_valid = in_req && memif_gnt;
      end
      addr_sel = rsp_wr ? dst_ptr : src_ptr;
   end

   assign memif_req   = in_req;
   assign memif_wen   = (state == ST_WR_REQ);
   assign memif_strb  = MEMIF_STRB_WORD;
   assign memif_addr  = {addr_sel[31:2], 2'b00};
   assign memif_wdata = buffer;
   assign g_clk_req   = busy | cfg_start | (state != ST_IDLE);

   always_ff @(posedge g_clk) begin
      if (!g_resetn) begin
         state      <= ST_IDLE;
         src_ptr    <= '0;
         dst_ptr    <= '0;
         buffer     <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         err        <= 1'b0;
         err_addr   <= '0;
         words_left <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (cfg_start && !busy) begin
                  src_ptr    <= {cfg_src[31:2], 2'b00};
                  dst_ptr    <= {cfg_dst[31:2], 2'b00};
                  words_left <= cfg_len;
                  err        <= 1'b0;
                  if (cfg_len == '0) begin
                     done <= 1'b1;
                     busy <= 1'b0;
                  end else begin
                     done  <= 1'b0;
                     busy  <= 1'b1;
                     state <= ST_RD_REQ;
                  end
               end
            end
            ST_RD_REQ: if (memif_gnt && DLY) state <= ST_RD_RSP;
            ST_WR_REQ: if (memif_gnt && DLY) state <= ST_WR_RSP;
            ST_RD_RSP, ST_WR_RSP: ;
            default: state <= ST_IDLE;
         endcase

         // Response handling overrides the request-state transitions above.
         if (rsp_valid) begin
            if (memif_error) begin
               err      <= 1'b1;
               err_addr <= addr_sel;
               busy     <= 1'b0;
               state    <= ST_IDLE;
            end else if (!rsp_wr) begin
               buffer <= memif_rdata;
               state  <= ST_WR_REQ;
            end else begin
               src_ptr    <= src_ptr + WORD_INC;
               dst_ptr    <= dst_ptr + WORD_INC;
               words_left <= words_left - LEN_W'(1);
               if (words_left == LEN_W'(1)) begin
                  done  <= 1'b1;
                  busy  <= 1'b0;
                  state <= ST_IDLE;
               end else begin
                  state <= ST_RD_REQ;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_memif_copy_dma.sv
// Testbench for memif_copy_dma: two instances (RSP_DELAY=0 and 1), each with
// its own memory model. Expected requests are queued per instance when a
// transfer is planned; a negedge monitor pops and compares every handshake
// and checks request stability across gnt stalls.
module tb_memif_copy_dma;

   typedef struct packed {
      logic        wen;
      logic [31:0] addr;
      logic [31:0] data;
   } exp_t;

   logic        g_clk;
   logic        rstn_s    [2];
   logic        start_s   [2];
   logic        clk_req_s [2];
   logic        busy_s    [2];
   logic        done_s    [2];
   logic        err_s     [2];
   logic        req_s     [2];
   logic        gnt_s     [2];
   logic        wen_s     [2];
   logic [31:0] src_s     [2];
   logic [31:0] dst_s     [2];
   logic [31:0] err_addr_s[2];
   logic [31:0] addr_s    [2];
   logic [31:0] wdata_s   [2];
   logic [15:0] len_s     [2];
   logic [15:0] wl_s      [2];
   logic [3:0]  strb_s    [2];

   logic [31:0] rdata0;
   logic        error0;
   logic [31:0] rsp_rdata;
   logic        rsp_err;

   logic [31:0] mem [2][256];
   logic        inj_en  [2];
   logic        inj_wen [2];
   logic [31:0] inj_addr[2];
   int          mode    [2];
   int          stall   [2];

   exp_t q0[$];
   exp_t q1[$];
   int   n_checks = 0;
   int   n_pass   = 0;

   logic        prev_stall[2];
   logic        prev_rst  [2];
   logic        prev_wen  [2];
   logic [31:0] prev_addr [2];
   logic [31:0] prev_wdata[2];

   initial g_clk = 1'b0;
   always #5 g_clk = ~g_clk;

   memif_copy_dma #(.LEN_W(16), .RSP_DELAY(0)) dut0 (
      .g_clk(g_clk), .g_resetn(rstn_s[0]), .g_clk_req(clk_req_s[0]),
      .cfg_start(start_s[0]), .cfg_src(src_s[0]), .cfg_dst(dst_s[0]), .cfg_len(len_s[0]),
      .busy(busy_s[0]), .done(done_s[0]), .err(err_s[0]), .err_addr(err_addr_s[0]),
      .words_left(wl_s[0]), .memif_req(req_s[0]), .memif_gnt(gnt_s[0]),
      .memif_wen(wen_s[0]), .memif_strb(strb_s[0]), .memif_addr(addr_s[0]),
      .memif_wdata(wdata_s[0]), .memif_rdata(rdata0), .memif_error(error0));

   memif_copy_dma #(.LEN_W(16), .RSP_DELAY(1)) dut1 (
      .g_clk(g_clk), .g_resetn(rstn_s[1]), .g_clk_req(clk_req_s[1]),
      .cfg_start(start_s[1]), .cfg_src(src_s[1]), .cfg_dst(dst_s[1]), .cfg_len(len_s[1]),
      .busy(busy_s[1]), .done(done_s[1]), .err(err_s[1]), .err_addr(err_addr_s[1]),
      .words_left(wl_s[1]), .memif_req(req_s[1]), .memif_gnt(gnt_s[1]),
      .memif_wen(wen_s[1]), .memif_strb(strb_s[1]), .memif_addr(addr_s[1]),
      .memif_wdata(wdata_s[1]), .memif_rdata(rsp_rdata), .memif_error(rsp_err));

   // Same-cycle responder for dut0.
   assign rdata0 = mem[0][addr_s[0][9:2]];
   assign error0 = req_s[0] && inj_en[0] && (addr_s[0] == inj_addr[0]) && (wen_s[0] == inj_wen[0]);

   task automatic check(input int i, input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL dut%0d %s: actual %h required %h", i, name, act, exp);
   endtask

   task automatic push(input int i, input logic w, input logic [31:0] a, input logic [31:0] d);
      exp_t e;
      e.wen = w; e.addr = a; e.data = d;
      if (i == 0) q0.push_back(e);
      else q1.push_back(e);
   endtask

   task automatic plan_copy(input int i, input logic [31:0] src, input logic [31:0] dst,
                            input int len, input logic [31:0] seed);
      for (int k = 0; k < len; k++) begin
         logic [31:0] a;
         a = src + 32'(4 * k);
         mem[i][a[9:2]] = seed + 32'(k);
         push(i, 1'b0, a, 32'h0);
         push(i, 1'b1, dst + 32'(4 * k), seed + 32'(k));
      end
   endtask

   task automatic check_mem(input int i, input string name, input logic [31:0] dst,
                            input int len, input logic [31:0] seed);
      for (int k = 0; k < len; k++) begin
         logic [31:0] a;
         a = dst + 32'(4 * k);
         check(i, name, mem[i][a[9:2]], seed + 32'(k));
      end
   endtask

   task automatic start_xfer(input int i, input logic [31:0] src, input logic [31:0] dst,
                             input logic [15:0] len);
      @(negedge g_clk);
      src_s[i] = src; dst_s[i] = dst; len_s[i] = len;
      start_s[i] = 1'b1;
      #1;
      check(i, "clk_req_on_start", clk_req_s[i], 1'b1);
      @(negedge g_clk);
      start_s[i] = 1'b0;
   endtask

   // Called at the negedge right after the accepting edge.
   task automatic run_xfer(input int i, input int budget, output int edges, output int reqs);
      edges = 0;
      reqs  = 0;
      while (busy_s[i] && edges < budget) begin
         reqs += int'(req_s[i]);
         @(negedge g_clk);
         edges++;
      end
      check(i, "xfer_finished", busy_s[i], 1'b0);
   endtask

   task automatic count_late_reqs(input int i, input int cycles, output int late);
      late = 0;
      repeat (cycles) begin
         @(negedge g_clk);
         late += int'(req_s[i]);
      end
   endtask

   task automatic mon_step(input int i);
      exp_t e;
      if (prev_stall[i] && prev_rst[i] && rstn_s[i]) begin
         check(i, "stall_req", req_s[i], 1'b1);
         check(i, "stall_wen", wen_s[i], prev_wen[i]);
         check(i, "stall_addr", addr_s[i], prev_addr[i]);
         check(i, "stall_wdata", wdata_s[i], prev_wdata[i]);
      end
      if (req_s[i] && gnt_s[i]) begin
         if ((i == 0 && q0.size() == 0) || (i == 1 && q1.size() == 0)) begin
            n_checks++;
            $display("FAIL dut%0d unexpected_req: actual addr %h wen %0b required no request",
                     i, addr_s[i], wen_s[i]);
         end else begin
            if (i == 0) e = q0.pop_front();
            else e = q1.pop_front();
            check(i, "req_wen", wen_s[i], e.wen);
            check(i, "req_addr", addr_s[i], e.addr);
            if (e.wen) check(i, "req_wdata", wdata_s[i], e.data);
         end
      end
      prev_stall[i] = req_s[i] && !gnt_s[i];
      prev_rst[i]   = rstn_s[i];
      prev_wen[i]   = wen_s[i];
      prev_addr[i]  = addr_s[i];
      prev_wdata[i] = wdata_s[i];
   endtask

   // Monitor
   initial begin
      for (int i = 0; i < 2; i++) begin
         prev_stall[i] = 1'b0; prev_rst[i] = 1'b0; prev_wen[i] = 1'b0;
         prev_addr[i] = '0; prev_wdata[i] = '0;
      end
      forever begin
         @(negedge g_clk);
         for (int i = 0; i < 2; i++) mon_step(i);
      end
   end

   // Grant driver: mode 0 = always high, 1 = random 0-5 cycle stalls, 2 = low.
   initial begin
      bit hs[2];
      for (int i = 0; i < 2; i++) begin gnt_s[i] = 1'b0; stall[i] = 0; end
      forever begin
         @(negedge g_clk);
         for (int i = 0; i < 2; i++) hs[i] = req_s[i] && gnt_s[i];
         @(posedge g_clk);
         #1;
         for (int i = 0; i < 2; i++) begin
            case (mode[i])
               0: gnt_s[i] = 1'b1;
               2: gnt_s[i] = 1'b0;
               default: begin
                  if (hs[i]) stall[i] = int'($urandom_range(0, 5));
                  if (req_s[i] && stall[i] == 0) gnt_s[i] = 1'b1;
                  else begin
                     gnt_s[i] = 1'b0;
                     if (req_s[i] && stall[i] > 0) stall[i]--;
                  end
               end
            endcase
         end
      end
   end

   // Memory model: writes on write handshakes; dut1 gets a registered response.
   initial begin
      logic hit;
      rsp_rdata = '0;
      rsp_err   = 1'b0;
      forever begin
         @(posedge g_clk);
         for (int i = 0; i < 2; i++) begin
            if (rstn_s[i] && req_s[i] && gnt_s[i]) begin
               hit = inj_en[i] && (addr_s[i] == inj_addr[i]) && (wen_s[i] == inj_wen[i]);
               if (i == 1) begin
                  rsp_rdata = mem[1][addr_s[1][9:2]];
                  rsp_err   = hit;
               end
               if (wen_s[i] && !hit) mem[i][addr_s[i][9:2]] = wdata_s[i];
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: actual still running required finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int edges, reqs, late, w;
      for (int i = 0; i < 2; i++) begin
         rstn_s[i] = 1'b0; start_s[i] = 1'b0; src_s[i] = '0; dst_s[i] = '0; len_s[i] = '0;
         inj_en[i] = 1'b0; inj_wen[i] = 1'b0; inj_addr[i] = '0; mode[i] = 0;
         for (int k = 0; k < 256; k++) mem[i][k] = '0;
      end
      repeat (3) @(negedge g_clk);
      for (int i = 0; i < 2; i++) begin
         check(i, "rst_busy", busy_s[i], 1'b0);
         check(i, "rst_done", done_s[i], 1'b0);
         check(i, "rst_err", err_s[i], 1'b0);
         check(i, "rst_err_addr", err_addr_s[i], 32'h0);
         check(i, "rst_words_left", wl_s[i], 16'h0);
         check(i, "rst_req", req_s[i], 1'b0);
         check(i, "rst_wen", wen_s[i], 1'b0);
         check(i, "rst_addr", addr_s[i], 32'h0);
         check(i, "rst_wdata", wdata_s[i], 32'h0);
         check(i, "rst_clk_req", clk_req_s[i], 1'b0);
         check(i, "strb", strb_s[i], 4'hF);
         rstn_s[i] = 1'b1;
      end

      // Basic copy, gnt tied high, same-cycle response: 2 cycles per word.
      plan_copy(0, 32'h100, 32'h200, 3, 32'hA1A1_0000);
      start_xfer(0, 32'h100, 32'h200, 16'd3);
      run_xfer(0, 40, edges, reqs);
      check(0, "t1_cycles", edges, 6);
      check(0, "t1_reqs", reqs, 6);
      check(0, "t1_done", done_s[0], 1'b1);
      check(0, "t1_err", err_s[0], 1'b0);
      check(0, "t1_words_left", wl_s[0], 16'h0);
      check_mem(0, "t1_mem", 32'h200, 3, 32'hA1A1_0000);

      // Random gnt stalls, plus a start pulse mid-transfer that must be ignored.
      mode[0] = 1;
      mem[0][8'hC0] = 32'h5555_5555;
      plan_copy(0, 32'h140, 32'h180, 5, 32'hB2B2_0000);
      start_xfer(0, 32'h140, 32'h180, 16'd5);
      check(0, "t2_done_cleared", done_s[0], 1'b0);
      check(0, "t2_busy", busy_s[0], 1'b1);
      check(0, "t2_words_left", wl_s[0], 16'd5);
      repeat (3) @(negedge g_clk);
      src_s[0] = 32'h300; dst_s[0] = 32'h3C0; len_s[0] = 16'd1; start_s[0] = 1'b1;
      @(negedge g_clk);
      start_s[0] = 1'b0;
      run_xfer(0, 300, edges, reqs);
      check(0, "t2_done", done_s[0], 1'b1);
      check(0, "t2_words_left_end", wl_s[0], 16'h0);
      check_mem(0, "t2_mem", 32'h180, 5, 32'hB2B2_0000);
      check(0, "t2_ignored_dst", mem[0][8'hF0], 32'h0);
      mode[0] = 0;

      // Read error on the second read.
      mem[0][8'h40] = 32'hC4C4_0000;
      mem[0][8'h41] = 32'hC4C4_0001;
      mem[0][8'h42] = 32'hC4C4_0002;
      mem[0][8'h89] = 32'hDEAD_BEEF;
      inj_en[0] = 1'b1; inj_wen[0] = 1'b0; inj_addr[0] = 32'h104;
      push(0, 1'b0, 32'h100, 32'h0);
      push(0, 1'b1, 32'h220, 32'hC4C4_0000);
      push(0, 1'b0, 32'h104, 32'h0);
      start_xfer(0, 32'h100, 32'h220, 16'd3);
      run_xfer(0, 40, edges, reqs);
      check(0, "t4_cycles", edges, 3);
      check(0, "t4_err", err_s[0], 1'b1);
      check(0, "t4_err_addr", err_addr_s[0], 32'h104);
      check(0, "t4_done", done_s[0], 1'b0);
      check(0, "t4_first_write", mem[0][8'h88], 32'hC4C4_0000);
      check(0, "t4_dst_plus4", mem[0][8'h89], 32'hDEAD_BEEF);
      count_late_reqs(0, 6, late);
      check(0, "t4_no_more_reqs", late, 0);
      inj_en[0] = 1'b0;

      // Zero-length start: done next cycle, never a request, err cleared.
      start_xfer(0, 32'h300, 32'h380, 16'd0);
      check(0, "t5_done", done_s[0], 1'b1);
      check(0, "t5_busy", busy_s[0], 1'b0);
      check(0, "t5_err_cleared", err_s[0], 1'b0);
      check(0, "t5_req", req_s[0], 1'b0);
      count_late_reqs(0, 4, late);
      check(0, "t5_no_reqs", late, 0);
      check(0, "q_empty", q0.size(), 0);

      // RSP_DELAY=1: req low in response cycles, 4 cycles per word.
      plan_copy(1, 32'h20, 32'h40, 2, 32'hD3D3_0000);
      start_xfer(1, 32'h20, 32'h40, 16'd2);
      run_xfer(1, 40, edges, reqs);
      check(1, "t3_cycles", edges, 8);
      check(1, "t3_req_cycles", reqs, 4);
      check(1, "t3_done", done_s[1], 1'b1);
      check(1, "t3_words_left", wl_s[1], 16'h0);
      check_mem(1, "t3_mem", 32'h40, 2, 32'hD3D3_0000);

      // RSP_DELAY=1 write error: err_addr is the destination.
      mem[1][8'h14] = 32'hE5E5_0001;
      inj_en[1] = 1'b1; inj_wen[1] = 1'b1; inj_addr[1] = 32'h60;
      push(1, 1'b0, 32'h50, 32'h0);
      push(1, 1'b1, 32'h60, 32'hE5E5_0001);
      start_xfer(1, 32'h50, 32'h60, 16'd2);
      run_xfer(1, 40, edges, reqs);
      check(1, "t4b_cycles", edges, 4);
      check(1, "t4b_err", err_s[1], 1'b1);
      check(1, "t4b_err_addr", err_addr_s[1], 32'h60);
      check(1, "t4b_done", done_s[1], 1'b0);
      count_late_reqs(1, 4, late);
      check(1, "t4b_no_more_reqs", late, 0);
      inj_en[1] = 1'b0;

      // Reset while a write request is outstanding.
      mem[1][8'h04] = 32'hF6F6_0001;
      push(1, 1'b0, 32'h10, 32'h0);
      start_xfer(1, 32'h10, 32'h80, 16'd4);
      mode[1] = 2;
      w = 0;
      while (!(req_s[1] && wen_s[1]) && w < 20) begin
         @(negedge g_clk);
         w++;
      end
      check(1, "t6_in_wr_req", req_s[1] && wen_s[1], 1'b1);
      rstn_s[1] = 1'b0;
      @(negedge g_clk);
      check(1, "t6_req", req_s[1], 1'b0);
      check(1, "t6_busy", busy_s[1], 1'b0);
      check(1, "t6_done", done_s[1], 1'b0);
      check(1, "t6_words_left", wl_s[1], 16'h0);
      check(1, "t6_wen", wen_s[1], 1'b0);
      check(1, "t6_addr", addr_s[1], 32'h0);
      check(1, "t6_wdata", wdata_s[1], 32'h0);
      check(1, "t6_clk_req", clk_req_s[1], 1'b0);
      rstn_s[1] = 1'b1;
      mode[1] = 0;

      // Source pointer wraps from 0xFFFFFFFC to 0x0.
      plan_copy(1, 32'hFFFF_FFFC, 32'h90, 2, 32'h0707_0000);
      start_xfer(1, 32'hFFFF_FFFC, 32'h90, 16'd2);
      run_xfer(1, 40, edges, reqs);
      check(1, "t7_cycles", edges, 8);
      check(1, "t7_done", done_s[1], 1'b1);
      check(1, "t7_err", err_s[1], 1'b0);
      check_mem(1, "t7_mem", 32'h90, 2, 32'h0707_0000);
      check(1, "q_empty", q1.size(), 0);

      repeat (2) @(negedge g_clk);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
